// File: rtl/led_display_hub75_rx.sv
// HUB75 serial row receiver: oversampled pins, row reconstruction, valid/ready row output.
// Optional: LED_DISPLAY_RX_PROTOCOL_CHECK_EN flags bit-clock rises seen while latch is high.
module led_display_hub75_rx #(
    parameter int NUM_COLS    = 64,
    parameter int ADDR_BITS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 n_reset_in,
    input  logic                 bit_clk_in,
    input  logic                 latch_in,
    input  logic                 red_top_in,
    input  logic                 green_top_in,
    input  logic                 blue_top_in,
    input  logic                 red_bot_in,
    input  logic                 green_bot_in,
    input  logic                 blue_bot_in,
    input  logic [ADDR_BITS-1:0] row_address_in,
    output logic [NUM_COLS-1:0]  red_top_out,
    output logic [NUM_COLS-1:0]  green_top_out,
    output logic [NUM_COLS-1:0]  blue_top_out,
    output logic [NUM_COLS-1:0]  red_bot_out,
    output logic [NUM_COLS-1:0]  green_bot_out,
    output logic [NUM_COLS-1:0]  blue_bot_out,
    output logic [ADDR_BITS-1:0] row_address_out,
    output logic                 row_valid_out,
    input  logic                 row_ready_in,
    output logic                 bit_count_error_out,
    output logic                 overflow_out,
    output logic                 protocol_error_out
);

    localparam int PW = 8 + ADDR_BITS;
    localparam int CW = $clog2(NUM_COLS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_COLS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_COLS + 1);

    localparam logic [0:0] ST_SYNC  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [PW-1:0]        pins;
    logic [PW-1:0]        sync_q [SYNC_STAGES];
    logic [PW-1:0]        p1_q;
    logic [1:0]           p2_q;
    logic                 bclk_rise_q;
    logic                 lat_rise_q;
    logic [5:0]           data_q;
    logic [ADDR_BITS-1:0] addr_q;

    logic [0:0]           state_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_COLS-1:0]  sh_q [6];
    logic [NUM_COLS-1:0]  sh_d [6];
    logic [NUM_COLS-1:0]  hold_q [6];

    assign pins = {row_address_in, latch_in, bit_clk_in, blue_bot_in, green_bot_in,
                   red_bot_in, blue_top_in, green_top_in, red_top_in};

    // Every pin takes the same path so data, clock, latch and address stay aligned;
    // edge detection is registered once more before the FSM acts on it.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            sync_q      <= '{default: '0};
            p1_q        <= '0;
            p2_q        <= '0;
            bclk_rise_q <= 1'b0;
            lat_rise_q  <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            p1_q        <= sync_q[SYNC_STAGES-1];
            p2_q        <= p1_q[7:6];
            bclk_rise_q <= p1_q[6] & ~p2_q[0];
            lat_rise_q  <= p1_q[7] & ~p2_q[1];
            data_q      <= p1_q[5:0];
            addr_q      <= p1_q[PW-1:8];
        end
    end

    // A bit arriving together with the latch is shifted first so the latch sees it.
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (state_q == ST_SHIFT && bclk_rise_q) begin
            for (int unsigned c = 0; c < 6; c++) sh_d[c] = {sh_q[c][NUM_COLS-2:0], data_q[c]};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q             <= ST_SYNC;
            cnt_q               <= '0;
            sh_q                <= '{default: '0};
            hold_q              <= '{default: '0};
            row_address_out     <= '0;
            row_valid_out       <= 1'b0;
            bit_count_error_out <= 1'b0;
            overflow_out        <= 1'b0;
        end else begin
            bit_count_error_out <= 1'b0;
            overflow_out        <= 1'b0;
            sh_q                <= sh_d;
            cnt_q               <= cnt_d;
            if (row_valid_out && row_ready_in) row_valid_out <= 1'b0;
            if (lat_rise_q) begin
                cnt_q <= '0;
                if (state_q == ST_SYNC) begin
                    state_q <= ST_SHIFT;
                end else if (cnt_d != CNT_FULL) begin
                    bit_count_error_out <= 1'b1;
                end else if (row_valid_out && !row_ready_in) begin
                    overflow_out <= 1'b1;
                end else begin
                    hold_q          <= sh_d;
                    row_address_out <= addr_q;
                    row_valid_out   <= 1'b1;
                end
            end
        end
    end

`ifdef LED_DISPLAY_RX_PROTOCOL_CHECK_EN
    logic lat_lvl_q;
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            lat_lvl_q          <= 1'b0;
            protocol_error_out <= 1'b0;
        end else begin
            lat_lvl_q          <= p1_q[7];
            protocol_error_out <= bclk_rise_q & lat_lvl_q;
        end
    end
`else
    assign protocol_error_out = 1'b0;
`endif

    assign red_top_out   = hold_q[0];
    assign green_top_out = hold_q[1];
    assign blue_top_out  = hold_q[2];
    assign red_bot_out   = hold_q[3];
    assign green_bot_out = hold_q[4];
    assign blue_bot_out  = hold_q[5];

endmodule

// File: tb/tb_led_display_hub75_rx.sv
// Scoreboard bench for led_display_hub75_rx: directed rows, errors, overflow, reset, latency.
module tb_led_display_hub75_rx;
    localparam int N  = 64;
    localparam int AB = 4;

    typedef struct packed {
        logic [N-1:0]  r1, g1, b1, r2, g2, b2;
        logic [AB-1:0] a;
    } row_t;

    logic clk = 0, rst_n = 0, bclk = 0, lat = 0, ready = 0;
    logic [5:0]    d = '0;
    logic [AB-1:0] addr = '0;

    logic [N-1:0]  rt, gt, bt, rb, gb, bb;
    logic [AB-1:0] ra;
    logic          vld, berr, ovf, perr;
    logic [N-1:0]  rt3, gt3, bt3, rb3, gb3, bb3;
    logic [AB-1:0] ra3;
    logic          vld3, berr3, ovf3, perr3;

    led_display_hub75_rx #(.NUM_COLS(N), .ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
        .clk_in(clk), .n_reset_in(rst_n), .bit_clk_in(bclk), .latch_in(lat),
        .red_top_in(d[0]), .green_top_in(d[1]), .blue_top_in(d[2]),
        .red_bot_in(d[3]), .green_bot_in(d[4]), .blue_bot_in(d[5]),
        .row_address_in(addr),
        .red_top_out(rt), .green_top_out(gt), .blue_top_out(bt),
        .red_bot_out(rb), .green_bot_out(gb), .blue_bot_out(bb),
        .row_address_out(ra), .row_valid_out(vld), .row_ready_in(ready),
        .bit_count_error_out(berr), .overflow_out(ovf), .protocol_error_out(perr));

    led_display_hub75_rx #(.NUM_COLS(N), .ADDR_BITS(AB), .SYNC_STAGES(3)) dut3 (
        .clk_in(clk), .n_reset_in(rst_n), .bit_clk_in(bclk), .latch_in(lat),
        .red_top_in(d[0]), .green_top_in(d[1]), .blue_top_in(d[2]),
        .red_bot_in(d[3]), .green_bot_in(d[4]), .blue_bot_in(d[5]),
        .row_address_in(addr),
        .red_top_out(rt3), .green_top_out(gt3), .blue_top_out(bt3),
        .red_bot_out(rb3), .green_bot_out(gb3), .blue_bot_out(bb3),
        .row_address_out(ra3), .row_valid_out(vld3), .row_ready_in(1'b1),
        .bit_count_error_out(berr3), .overflow_out(ovf3), .protocol_error_out(perr3));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int berr_cnt = 0, ovf_cnt = 0, perr_cnt = 0, xfer_cnt = 0;
    int cyc = 0, rise2 = -1, rise3 = -1, c0 = 0;
    logic v2p = 0, v3p = 0;
    row_t q[$];
    row_t exp_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (berr) berr_cnt++;
        if (ovf)  ovf_cnt++;
        if (perr) perr_cnt++;
        if (vld && !v2p) rise2 = cyc;
        if (vld3 && !v3p) rise3 = cyc;
        v2p = vld;
        v3p = vld3;
        if (vld && ready) begin
            xfer_cnt++;
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_row actual=%0h required=none", rt);
            end else begin
                exp_r = q.pop_front();
                chk("row_r1", rt, exp_r.r1);
                chk("row_g1", gt, exp_r.g1);
                chk("row_b1", bt, exp_r.b1);
                chk("row_r2", rb, exp_r.r2);
                chk("row_g2", gb, exp_r.g2);
                chk("row_b2", bb, exp_r.b2);
                chk("row_addr", 64'(ra), 64'(exp_r.a));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] bits_of(input row_t r, input int k);
        return {r.b2[k], r.g2[k], r.r2[k], r.b1[k], r.g1[k], r.r1[k]};
    endfunction

    task automatic send_bit(input logic [5:0] b);
        d = b; tick(2);
        bclk = 1; tick(3);
        bclk = 0; tick(1);
    endtask

    task automatic shift_row(input row_t r, input int nbits);
        for (int k = 0; k < nbits; k++) send_bit(bits_of(r, (k < N) ? N - 1 - k : 0));
    endtask

    task automatic pulse_latch(input logic [AB-1:0] a);
        addr = a; tick(2);
        lat = 1; tick(3);
        lat = 0; tick(8);
    endtask

    task automatic good_row(input row_t r, input bit expect_xfer);
        addr = r.a;
        shift_row(r, N);
        if (expect_xfer) q.push_back(r);
        pulse_latch(r.a);
    endtask

    row_t ra_row, rb_row, rc_row, rd_row, re_row, rf_row, rg_row;

    initial begin
        ra_row = '{r1: 64'h8000_0000_0000_0001, g1: 64'h0123_4567_89AB_CDEF, b1: '0,
                   r2: '1, g2: 64'hF0F0_F0F0_F0F0_F0F0, b2: 64'h0000_0000_FFFF_0000, a: 4'd5};
        rb_row = '{r1: 64'hDEAD_BEEF_CAFE_F00D, g1: 64'h1, b1: 64'h8000_0000_0000_0000,
                   r2: 64'h5555_5555_5555_5555, g2: '0, b2: 64'hAAAA_0000_5555_FFFF, a: 4'd9};
        rc_row = '{r1: 64'h1234_5678_9ABC_DEF0, g1: 64'hFFFF_0000_FFFF_0000, b1: 64'h3,
                   r2: 64'h0F, g2: 64'hC000_0000_0000_0003, b2: 64'h7, a: 4'd3};
        rd_row = '{r1: 64'hAAAA_AAAA_AAAA_AAAA, g1: '1, b1: '1, r2: '1, g2: '1, b2: '1, a: 4'd12};
        re_row = '{r1: 64'hFFFF_FFFF_0000_0000, g1: 64'h1111, b1: 64'h2222, r2: 64'h3333,
                   g2: 64'h4444, b2: 64'h5555, a: 4'd7};
        rf_row = '{r1: 64'h0000_0000_0000_8001, g1: 64'h8421_8421_8421_8421, b1: 64'h1248,
                   r2: 64'hFEDC_BA98_7654_3210, g2: 64'h6, b2: 64'h9, a: 4'd14};
        rg_row = '{r1: 64'h0F1E_2D3C_4B5A_6978, g1: 64'h1, b1: 64'h2, r2: 64'h3, g2: 64'h4,
                   b2: 64'h8000_0000_0000_0001, a: 4'd10};

        // reset state
        tick(3);
        chk("reset_valid", 64'(vld), 64'd0);
        chk("reset_r1", rt, 64'd0);
        chk("reset_addr", 64'(ra), 64'd0);
        rst_n = 1; tick(2);
        ready = 1;

        // basic row
        pulse_latch(4'd0);
        good_row(ra_row, 1);
        chk("basic_xfers", 64'(xfer_cnt), 64'd1);
        chk("basic_no_err", 64'(berr_cnt + ovf_cnt), 64'd0);

        // short and long rows
        shift_row(rb_row, N - 1); pulse_latch(4'd1);
        chk("short_err", 64'(berr_cnt), 64'd1);
        shift_row(rb_row, N + 1); pulse_latch(4'd2);
        chk("long_err", 64'(berr_cnt), 64'd2);
        chk("bad_rows_no_xfer", 64'(xfer_cnt), 64'd1);
        good_row(rb_row, 1);
        chk("after_err_xfers", 64'(xfer_cnt), 64'd2);

        // backpressure and overflow
        ready = 0;
        good_row(rc_row, 1);
        chk("held_valid", 64'(vld), 64'd1);
        chk("held_r1", rt, rc_row.r1);
        good_row(rd_row, 0);
        chk("overflow_pulse", 64'(ovf_cnt), 64'd1);
        chk("held_stable_r1", rt, rc_row.r1);
        chk("held_stable_addr", 64'(ra), 64'(rc_row.a));
        ready = 1; tick(4);
        chk("release_xfers", 64'(xfer_cnt), 64'd3);
        chk("release_valid_low", 64'(vld), 64'd0);

        // reset mid-row, then SYNC discards the first row
        shift_row(re_row, 30);
        rst_n = 0; tick(2);
        chk("midreset_valid", 64'(vld), 64'd0);
        chk("midreset_r1", rt, 64'd0);
        chk("midreset_addr", 64'(ra), 64'd0);
        rst_n = 1; tick(2);
        shift_row(re_row, N); pulse_latch(re_row.a);
        chk("sync_discard", 64'(xfer_cnt), 64'd3);
        chk("sync_no_err", 64'(berr_cnt), 64'd2);
        good_row(rf_row, 1);
        chk("post_sync_xfer", 64'(xfer_cnt), 64'd4);

        // bit clock and latch rise together on the last bit
        addr = rg_row.a;
        shift_row(rg_row, N - 1);
        d = bits_of(rg_row, 0); tick(2);
        q.push_back(rg_row);
        rise2 = -1; rise3 = -1;
        bclk = 1; lat = 1; c0 = cyc;
        tick(3);
        bclk = 0; lat = 0; tick(12);
        chk("coincide_xfer", 64'(xfer_cnt), 64'd5);
        chk("latency_s2", 64'(rise2 - (c0 + 1)), 64'd4);
        chk("latency_s3", 64'(rise3 - (c0 + 1)), 64'd5);

        // bit clock toggled during a latch pulse
        lat = 1; tick(2);
        for (int i = 0; i < 2; i++) begin
            bclk = 1; tick(2);
            bclk = 0; tick(2);
        end
        lat = 0; tick(10);
        chk("latch_zero_bits_err", 64'(berr_cnt), 64'd3);
`ifdef LED_DISPLAY_RX_PROTOCOL_CHECK_EN
        chk("protocol_pulses", 64'(perr_cnt), 64'd3);
`else
        chk("protocol_pulses", 64'(perr_cnt), 64'd0);
`endif

        chk("final_xfers", 64'(xfer_cnt), 64'd5);
        chk("final_overflow", 64'(ovf_cnt), 64'd1);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
